// File: rtl/wall_collision_sequencer.sv
// -----------------------------------------------------------------------------
// wall_collision_sequencer
//
// Purpose:
//   Per-frame wall-collision stage for the pool table. On each physics tick it
//   latches the ball position and heading and tests them against the four
//   cushions. For every cushion hit it asks the external (combinational)
//   reflection_helper for the reflected heading and then re-checks the new
//   heading. This lets a corner resolve in one frame, with at most two
//   reflections. The final heading goes to the motion integrator together
//   with a one-cycle done pulse.
//
// Ports:
//   clk_in           in   1   system clock
//   rst_n_in         in   1   asynchronous active-low reset
//   tick_in          in   1   frame strobe; ball_x/y/dir are valid this cycle
//   ball_x_in        in  11   ball centre x (pixels)
//   ball_y_in        in  10   ball centre y (pixels)
//   ball_dir_in      in  16   heading in degrees (0..359, 360..719 folded)
//   refl_wall_out    out  2   wall code to helper: 0=+x 1=+y 2=-x 3=-y
//   refl_dir_out     out 16   heading to helper
//   refl_new_dir_in  in  16   reflected heading from helper
//   busy_out         out  1   high while a frame is being resolved
//   done_out         out  1   one-cycle pulse, dir_out valid
//   hit_out          out  1   pulses with done_out if any reflection occurred
//   dir_out          out 16   resolved heading, held until next done
//   bounce_cnt_out   out 16   (COLLIDER_STATS_EN only) total reflections,
//                             saturating
//
// Configuration macro:
//   COLLIDER_STATS_EN - adds the saturating bounce counter and its port.
// -----------------------------------------------------------------------------
module wall_collision_sequencer #(
    parameter int X_MIN          = 0,
    parameter int X_MAX          = 1023,
    parameter int Y_MIN          = 0,
    parameter int Y_MAX          = 511,
    parameter int BALL_R         = 8,
    parameter int COOLDOWN_TICKS = 3
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        tick_in,
    input  logic [10:0] ball_x_in,
    input  logic [9:0]  ball_y_in,
    input  logic [15:0] ball_dir_in,
    output logic [1:0]  refl_wall_out,
    output logic [15:0] refl_dir_out,
    input  logic [15:0] refl_new_dir_in,
    output logic        busy_out,
    output logic        done_out,
    output logic        hit_out,
    output logic [15:0] dir_out
`ifdef COLLIDER_STATS_EN
    ,
    output logic [15:0] bounce_cnt_out
`endif
);

    localparam int CD_W = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS + 1) : 1;
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_TICKS);

    // Contact thresholds, all compared in 12-bit unsigned arithmetic
    localparam logic [11:0] X_HI_LIM = 12'(X_MAX);
    localparam logic [11:0] Y_HI_LIM = 12'(Y_MAX);
    localparam logic [11:0] X_LO_LIM = 12'(X_MIN + BALL_R);
    localparam logic [11:0] Y_LO_LIM = 12'(Y_MIN + BALL_R);
    localparam logic [11:0] RADIUS   = 12'(BALL_R);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        REFLECT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [10:0]     pos_x;
    logic [9:0]      pos_y;
    logic [15:0]     cur_dir;
    logic [1:0]      refl_count;
    logic [CD_W-1:0] cooldown [4];

    logic [11:0] x_ext;
    logic [11:0] y_ext;
    logic [3:0]  cand;
    logic [1:0]  sel_wall;
    logic        any_cand;
    logic [15:0] tick_dir;
    logic [15:0] new_dir;

    assign x_ext = {1'b0, pos_x};
    assign y_ext = {2'b00, pos_y};

    // Headings of 360..719 are folded once on entry; helper results of 360
    // (e.g. a +y reflection of heading 0) are folded the same way.
    assign tick_dir = (ball_dir_in >= 16'd360) ? (ball_dir_in - 16'd360) : ball_dir_in;
    assign new_dir  = (refl_new_dir_in >= 16'd360) ? (refl_new_dir_in - 16'd360)
                                                   : refl_new_dir_in;

    // A cushion is a candidate only if it is armed, the ball touches it and
    // the heading points into it. Exact 90/270 never hit the x cushions and
    // exact 0/180 never hit the y cushions because all bounds are strict.
    always_comb begin
        cand    = 4'b0000;
        cand[0] = (cooldown[0] == '0) && ((x_ext + RADIUS) >= X_HI_LIM)
                  && ((cur_dir < 16'd90) || (cur_dir > 16'd270));
        cand[1] = (cooldown[1] == '0) && ((y_ext + RADIUS) >= Y_HI_LIM)
                  && (cur_dir > 16'd0) && (cur_dir < 16'd180);
        cand[2] = (cooldown[2] == '0) && (x_ext <= X_LO_LIM)
                  && (cur_dir > 16'd90) && (cur_dir < 16'd270);
        cand[3] = (cooldown[3] == '0) && (y_ext <= Y_LO_LIM)
                  && (cur_dir > 16'd180) && (cur_dir < 16'd360);
    end

    // Fixed priority: wall 0 beats 1 beats 2 beats 3
    always_comb begin
        sel_wall = 2'd0;
        if (cand[0]) begin
            sel_wall = 2'd0;
        end else if (cand[1]) begin
            sel_wall = 2'd1;
        end else if (cand[2]) begin
            sel_wall = 2'd2;
        end else if (cand[3]) begin
            sel_wall = 2'd3;
        end
    end

    assign any_cand = |cand;

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; the reflection count caps a frame at two bounces
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (tick_in) begin
                    next_state = CHECK;
                end
            end
            CHECK: begin
                if (any_cand && (refl_count < 2'd2)) begin
                    next_state = REFLECT;
                end else begin
                    next_state = DONE;
                end
            end
            REFLECT: next_state = CHECK;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A tick arriving outside IDLE is simply not seen, so busy is just "not idle"
    assign busy_out = (state != IDLE);

    // Datapath: latched ball state, cooldowns, helper interface and results.
    // refl_* are only written when entering REFLECT so they hold otherwise.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pos_x         <= '0;
            pos_y         <= '0;
            cur_dir       <= '0;
            refl_count    <= '0;
            refl_wall_out <= '0;
            refl_dir_out  <= '0;
            done_out      <= 1'b0;
            hit_out       <= 1'b0;
            dir_out       <= '0;
            for (int i = 0; i < 4; i++) begin
                cooldown[i] <= '0;
            end
`ifdef COLLIDER_STATS_EN
            bounce_cnt_out <= '0;
`endif
        end else begin
            done_out <= 1'b0;
            hit_out  <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick_in) begin
                        pos_x   <= ball_x_in;
                        pos_y   <= ball_y_in;
                        cur_dir <= tick_dir;
                        for (int i = 0; i < 4; i++) begin
                            if (cooldown[i] != '0) begin
                                cooldown[i] <= cooldown[i] - CD_W'(1);
                            end
                        end
                    end
                end
                CHECK: begin
                    if (next_state == REFLECT) begin
                        refl_wall_out <= sel_wall;
                        refl_dir_out  <= cur_dir;
                    end
                end
                REFLECT: begin
                    cur_dir                 <= new_dir;
                    cooldown[refl_wall_out] <= CD_LOAD;
                    refl_count              <= refl_count + 2'd1;
`ifdef COLLIDER_STATS_EN
                    if (bounce_cnt_out != 16'hFFFF) begin
                        bounce_cnt_out <= bounce_cnt_out + 16'd1;
                    end
`endif
                end
                DONE: begin
                    dir_out    <= cur_dir;
                    done_out   <= 1'b1;
                    hit_out    <= (refl_count != 2'd0);
                    refl_count <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
